// File: rtl/mem_arb_ctrl.sv
// Two-port round-robin arbiter/sequencer for a 32x8 synchronous memory; MEM_ARB_CLEAR_EN adds a zero-fill engine.
// Latency: gnt + strobe one cycle after req is seen in IDLE; read rvalid/rdata two cycles after the strobe.
// Backpressure: a requester holds req/we/addr/wdata until it sees gnt; each grant costs 2 (write) or 3 (read) cycles.
module mem_arb_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              we_0,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              rvalid_0,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA, CLEAR} state_t;

    state_t            state;
    logic              rr_ptr;
    logic              cur_port;
    logic              cur_we;

    logic              win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // rr_ptr only matters on a tie; a lone requester always wins.
    always_comb begin
        win       = (req_0 && req_1) ? rr_ptr : req_1;
        win_we    = win ? we_1 : we_0;
        win_addr  = win ? addr_1 : addr_0;
        win_wdata = win ? wdata_1 : wdata_0;
    end

`ifdef MEM_ARB_CLEAR_EN
    logic clear_pend;
`else
    logic unused_clear;
    assign unused_clear = clear_start | (DEPTH == 0);
    assign clear_busy   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            cur_port    <= 1'b0;
            cur_we      <= 1'b0;
            gnt_0       <= 1'b0;
            gnt_1       <= 1'b0;
            rvalid_0    <= 1'b0;
            rvalid_1    <= 1'b0;
            rdata_0     <= '0;
            rdata_1     <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
`ifdef MEM_ARB_CLEAR_EN
            clear_busy  <= 1'b0;
            clear_pend  <= 1'b0;
`endif
        end else begin
            gnt_0     <= 1'b0;
            gnt_1     <= 1'b0;
            rvalid_0  <= 1'b0;
            rvalid_1  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
`ifdef MEM_ARB_CLEAR_EN
            if (clear_start && !clear_busy) begin
                clear_pend <= 1'b1;
            end
`endif
            case (state)
                IDLE: begin
`ifdef MEM_ARB_CLEAR_EN
                    // A start pulse seen this cycle beats a request arriving in the same cycle.
                    if (clear_pend || clear_start) begin
                        state       <= CLEAR;
                        clear_pend  <= 1'b0;
                        clear_busy  <= 1'b1;
                        mem_write   <= 1'b1;
                        mem_addr    <= '0;
                        mem_data_in <= '0;
                    end else
`endif
                    if (req_0 || req_1) begin
                        state       <= ACCESS;
                        cur_port    <= win;
                        cur_we      <= win_we;
                        rr_ptr      <= ~win;
                        gnt_0       <= ~win;
                        gnt_1       <= win;
                        mem_read    <= ~win_we;
                        mem_write   <= win_we;
                        mem_addr    <= win_addr;
                        mem_data_in <= win_wdata;
                    end
                end
                ACCESS: begin
                    state <= cur_we ? IDLE : RDATA;
                end
                RDATA: begin
                    state <= IDLE;
                    if (cur_port) begin
                        rdata_1  <= mem_data_out;
                        rvalid_1 <= 1'b1;
                    end else begin
                        rdata_0  <= mem_data_out;
                        rvalid_0 <= 1'b1;
                    end
                end
                CLEAR: begin
`ifdef MEM_ARB_CLEAR_EN
                    // mem_addr doubles as the sweep counter and is left at DEPTH-1 afterwards.
                    if (mem_addr == ADDR_W'(DEPTH - 1)) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                    end else begin
                        mem_write <= 1'b1;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
